// File: rtl/sram_pkg.sv
// sram_pkg: supply/threshold constants and read-FSM state encoding shared by the SRAM read path
// Used by the read controller, the sense amplifier model and the array model.
package sram_pkg;
    parameter real VDD = 1.5;
    parameter real VSS = 0.0;
    parameter real VTH = 0.8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_WL   = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;
    typedef enum logic [1:0] {IDLE = S_IDLE, PRE = S_PRE, WL = S_WL, OUT = S_OUT} rd_state_t;
endpackage

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter timing one FSM phase
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset, clears the count
//   i_load     load i_load_val on this edge (phase entry)
//   i_load_val phase length minus one
//   o_done     count has reached zero; the current cycle is the phase's last
module sram_phase_timer
    import sram_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);
    logic [W-1:0] r_count;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - W'(1);
    end
    assign o_done = r_count == '0;
endmodule

// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl: read sequencer (precharge, word line, capture) with host valid/ack handshake
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_rd_req        read request, taken only while o_rd_rdy=1
//   i_rd_addr       row address, latched on accept
//   o_rd_rdy        controller idle
//   o_precharge     bitline precharge drive (VDD during PRE, else VSS)
//   o_row_rd        one-hot row select voltages (VDD on the latched row during WL)
//   i_preout        sense-amp output voltages, thresholded at VTH
//   o_rd_data       captured word, loaded on the last WL cycle
//   o_rd_valid      o_rd_data valid, held until i_rd_ack
//   i_rd_ack        host consumes the word
//   o_rd_err        one-cycle pulse for an out-of-range address
module sram_read_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int T_PRE = 2,
    parameter int T_WL  = 3,
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rd_req,
    input  logic [AW-1:0]   i_rd_addr,
    output logic            o_rd_rdy,
    output real             o_precharge,
    output real             o_row_rd [0:ROWS-1],
    input  real             i_preout [0:0][0:COLS-1],
    output logic [COLS-1:0] o_rd_data,
    output logic            o_rd_valid,
    input  logic            i_rd_ack,
    output logic            o_rd_err
);
    localparam int TMAX = (T_PRE > T_WL) ? T_PRE : T_WL;
    localparam int TW   = $clog2(TMAX + 1);
    rd_state_t       r_state;
    logic [AW-1:0]   r_addr;
    logic [COLS-1:0] r_rd_data;
    logic            r_rd_err;
    logic [COLS-1:0] w_bits;
    logic [31:0]     w_addr_ext;
    logic            w_addr_ok;
    logic            w_accept;
    logic            w_load;
    logic            w_done;
    logic [TW-1:0]   w_load_val;
    // Widen before comparing so the range test stays meaningful when ROWS is a power of two.
    assign w_addr_ext = 32'(i_rd_addr);
    assign w_addr_ok  = w_addr_ext < 32'(ROWS);
    assign w_accept   = (r_state == IDLE) && i_rd_req;
    // The single timer is reloaded on entry to PRE and again on entry to WL.
    assign w_load     = (w_accept && w_addr_ok) || (r_state == PRE && w_done);
    assign w_load_val = (r_state == IDLE) ? TW'(T_PRE - 1) : TW'(T_WL - 1);
    sram_phase_timer #(.W(TW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rd_data <= '0;
            r_rd_err  <= 1'b0;
        end else begin
            r_rd_err <= w_accept && !w_addr_ok;
            case (r_state)
                IDLE: if (w_accept && w_addr_ok) begin
                    r_state <= PRE;
                    r_addr  <= i_rd_addr;
                end
                PRE: if (w_done) r_state <= WL;
                WL: if (w_done) begin
                    r_state   <= OUT;
                    r_rd_data <= w_bits;
                end
                OUT: if (i_rd_ack) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
    // Analog drive decoded straight from state: a reset edge drops rows and precharge at once,
    // and PRE/WL exclusivity guarantees precharge and any row never overlap.
    assign o_precharge = (r_state == PRE) ? VDD : VSS;
    for (genvar g = 0; g < ROWS; g++) begin : g_row
        assign o_row_rd[g] = (r_state == WL && 32'(r_addr) == g) ? VDD : VSS;
    end
    for (genvar g = 0; g < COLS; g++) begin : g_bit
        assign w_bits[g] = i_preout[0][g] >= VTH;
    end
    assign o_rd_rdy   = r_state == IDLE;
    assign o_rd_valid = r_state == OUT;
    assign o_rd_data  = r_rd_data;
    assign o_rd_err   = r_rd_err;
endmodule

// File: tb/tb_sram_read_ctrl.sv
// tb_sram_read_ctrl: randomized self-checking bench for sram_read_ctrl against a cycle-timeline model
module tb_sram_read_ctrl;
    localparam int T_PRE = 2;
    localparam int T_WL  = 3;
    localparam int LAT   = T_PRE + T_WL + 1;
    logic       clk = 0, rst_n = 0, req = 0, ack = 0, req6 = 0, ack6 = 0;
    logic [2:0] addr = 0, addr6 = 0;
    logic       rdy, valid, err, rdy6, valid6, err6;
    logic [7:0] data, data6;
    real        prech, prech6;
    real        row_rd [0:7];
    real        row6 [0:5];
    real        preout [0:0][0:7];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_read_ctrl #(.ROWS(8), .COLS(8), .T_PRE(T_PRE), .T_WL(T_WL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(req), .i_rd_addr(addr), .o_rd_rdy(rdy),
        .o_precharge(prech), .o_row_rd(row_rd), .i_preout(preout), .o_rd_data(data),
        .o_rd_valid(valid), .i_rd_ack(ack), .o_rd_err(err)
    );

    sram_read_ctrl #(.ROWS(6), .COLS(8), .T_PRE(T_PRE), .T_WL(T_WL)) dut6 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(req6), .i_rd_addr(addr6), .o_rd_rdy(rdy6),
        .o_precharge(prech6), .o_row_rd(row6), .i_preout(preout), .o_rd_data(data6),
        .o_rd_valid(valid6), .i_rd_ack(ack6), .o_rd_err(err6)
    );

    // Expected word straight from the threshold rule: volts >= 0.8 reads as 1.
    function automatic logic [7:0] model_word();
        logic [7:0] w;
        for (int c = 0; c < 8; c++) w[c] = preout[0][c] >= 0.8;
        return w;
    endfunction

    task automatic set_bits(input logic [7:0] b);
        for (int c = 0; c < 8; c++) preout[0][c] = b[c] ? 1.5 : 0.0;
    endtask

    task automatic set_random_volts();
        for (int c = 0; c < 8; c++) preout[0][c] = real'($urandom_range(0, 150)) / 100.0;
    endtask

    // One access on the 8-row instance, checked cycle by cycle: cycle k is the k-th cycle after
    // the accept edge; precharge in 1..T_PRE, row a in T_PRE+1..T_PRE+T_WL, valid from LAT on.
    task automatic do_read(input logic [2:0] a);
        logic [7:0] expw;
        expw = model_word();
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("FAIL pre_accept_rdy got %b exp 1", rdy); end
        req = 1; addr = a;
        for (int k = 1; k <= LAT; k++) begin
            real ep;
            @(negedge clk);
            if (k == 1) req = 0;
            ep = (k <= T_PRE) ? 1.5 : 0.0;
            checks++;
            if (prech != ep) begin errors++; $display("FAIL precharge k=%0d got %f exp %f", k, prech, ep); end
            for (int r = 0; r < 8; r++) begin
                real er;
                er = (r == int'(a) && k > T_PRE && k <= T_PRE + T_WL) ? 1.5 : 0.0;
                checks++;
                if (row_rd[r] != er) begin errors++; $display("FAIL row_rd[%0d] k=%0d got %f exp %f", r, k, row_rd[r], er); end
            end
            checks++;
            if (valid !== (k == LAT)) begin errors++; $display("FAIL rd_valid k=%0d got %b exp %b", k, valid, k == LAT); end
            checks++;
            if (rdy !== 1'b0) begin errors++; $display("FAIL rd_rdy_busy k=%0d got %b exp 0", k, rdy); end
        end
        checks++;
        if (data !== expw) begin errors++; $display("FAIL rd_data addr=%0d got %h exp %h", a, data, expw); end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdy !== 1'b1 || valid !== 1'b0 || data !== 8'h00 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags got rdy=%b valid=%b data=%h err=%b exp 1 0 00 0", rdy, valid, data, err);
        end
        checks++;
        if (prech != 0.0) begin errors++; $display("FAIL reset_precharge got %f exp 0.0", prech); end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_rd[r] != 0.0) begin errors++; $display("FAIL reset_row[%0d] got %f exp 0.0", r, row_rd[r]); end
        end
        rst_n = 1;
        ack = 1;
        @(negedge clk);
        ack = 0;
        checks++;
        if (rdy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL stray_ack got rdy=%b valid=%b exp 1 0", rdy, valid); end
    endtask

    task automatic test_basic();
        set_bits(8'hA5);
        do_read(3'd3);
        checks++;
        if (data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data); end
        ack = 1;
        @(negedge clk);
        ack = 0;
        checks++;
        if (valid !== 1'b0 || rdy !== 1'b1) begin errors++; $display("FAIL basic_ack got valid=%b rdy=%b exp 0 1", valid, rdy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] held;
            set_random_volts();
            do_read(3'($urandom_range(0, 7)));
            held = model_word();
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checks++;
                if (valid !== 1'b1 || data !== held) begin errors++; $display("FAIL random_hold got valid=%b data=%h exp 1 %h", valid, data, held); end
            end
            ack = 1;
            @(negedge clk);
            ack = 0;
            checks++;
            if (valid !== 1'b0) begin errors++; $display("FAIL random_ack got valid=%b exp 0", valid); end
        end
    endtask

    task automatic test_hold_ack();
        logic [7:0] held;
        bit         seen;
        set_bits(8'($urandom));
        held = model_word();
        do_read(3'($urandom_range(0, 7)));
        for (int i = 0; i < 10; i++) begin
            req = 1; addr = 3'($urandom_range(0, 7));
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || data !== held || rdy !== 1'b0) begin
                errors++; $display("FAIL hold cyc=%0d got valid=%b data=%h rdy=%b exp 1 %h 0", i, valid, data, rdy, held);
            end
            checks++;
            if (prech != 0.0) begin errors++; $display("FAIL hold_precharge cyc=%0d got %f exp 0.0", i, prech); end
        end
        set_bits(8'h3C);
        req = 1; addr = 3'd5; ack = 1;
        @(negedge clk);
        ack = 0;
        checks++;
        if (valid !== 1'b0 || rdy !== 1'b1 || prech != 0.0) begin
            errors++; $display("FAIL ack_with_req got valid=%b rdy=%b prech=%f exp 0 1 0.0", valid, rdy, prech);
        end
        @(negedge clk);
        req = 0;
        checks++;
        if (rdy !== 1'b0 || prech != 1.5) begin errors++; $display("FAIL req_after_ack got rdy=%b prech=%f exp 0 1.5", rdy, prech); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL req_after_ack_valid got timeout exp rd_valid=1"); end
        checks++;
        if (data !== 8'h3C) begin errors++; $display("FAIL req_after_ack_data got %h exp 3c", data); end
        ack = 1;
        @(negedge clk);
        ack = 0;
    endtask

    task automatic test_threshold();
        for (int c = 0; c < 8; c++)
            preout[0][c] = (c % 4 == 0) ? 0.8 : (c % 4 == 1) ? 0.79 : (c % 4 == 2) ? 1.5 : 0.0;
        do_read(3'd6);
        checks++;
        if (data !== 8'h55) begin errors++; $display("FAIL threshold_data got %h exp 55", data); end
        ack = 1;
        @(negedge clk);
        ack = 0;
    endtask

    task automatic test_bad_addr();
        logic [7:0] expw;
        bit         seen;
        for (int b = 6; b <= 7; b++) begin
            req6 = 1; addr6 = 3'(b);
            @(negedge clk);
            req6 = 0;
            checks++;
            if (err6 !== 1'b1 || rdy6 !== 1'b1 || valid6 !== 1'b0) begin
                errors++; $display("FAIL bad_addr=%0d got err=%b rdy=%b valid=%b exp 1 1 0", b, err6, rdy6, valid6);
            end
            checks++;
            if (prech6 != 0.0) begin errors++; $display("FAIL bad_addr_prech got %f exp 0.0", prech6); end
            @(negedge clk);
            checks++;
            if (err6 !== 1'b0 || valid6 !== 1'b0) begin errors++; $display("FAIL bad_addr_pulse got err=%b valid=%b exp 0 0", err6, valid6); end
            for (int r = 0; r < 6; r++) begin
                checks++;
                if (row6[r] != 0.0) begin errors++; $display("FAIL bad_addr_row[%0d] got %f exp 0.0", r, row6[r]); end
            end
        end
        set_bits(8'h96);
        expw = model_word();
        req6 = 1; addr6 = 3'd5;
        @(negedge clk);
        req6 = 0;
        checks++;
        if (err6 !== 1'b0 || prech6 != 1.5) begin errors++; $display("FAIL top_addr_accept got err=%b prech=%f exp 0 1.5", err6, prech6); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (row6[5] == 1.5) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL top_addr_row got timeout exp row_rd[5]=1.5"); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid6;
        end
        checks++;
        if (!seen || data6 !== expw) begin errors++; $display("FAIL top_addr_read got valid=%b data=%h exp 1 %h", seen, data6, expw); end
        ack6 = 1;
        @(negedge clk);
        ack6 = 0;
    endtask

    task automatic test_reset_wl();
        logic [2:0] a;
        a = 3'($urandom_range(0, 7));
        set_random_volts();
        req = 1; addr = a;
        for (int k = 1; k <= T_PRE + 2; k++) begin
            @(negedge clk);
            if (k == 1) req = 0;
        end
        checks++;
        if (row_rd[a] != 1.5) begin errors++; $display("FAIL wl2_row got %f exp 1.5", row_rd[a]); end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        checks++;
        if (rdy !== 1'b1 || valid !== 1'b0 || prech != 0.0) begin
            errors++; $display("FAIL wl_reset got rdy=%b valid=%b prech=%f exp 1 0 0.0", rdy, valid, prech);
        end
        for (int r = 0; r < 8; r++) begin
            checks++;
            if (row_rd[r] != 0.0) begin errors++; $display("FAIL wl_reset_row[%0d] got %f exp 0.0", r, row_rd[r]); end
        end
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || row_rd[a] != 0.0) begin errors++; $display("FAIL wl_reset_after k=%0d got valid=%b row=%f exp 0 0.0", k, valid, row_rd[a]); end
        end
    endtask

    initial begin
        for (int c = 0; c < 8; c++) preout[0][c] = 0.0;
        test_reset();
        test_basic();
        test_random();
        test_hold_ack();
        test_threshold();
        test_bad_addr();
        test_reset_wl();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
